store_buffer: RTL and testbench

- Posted-write buffer between the MEM-stage memory handler and the data memory port.
- Accepts word-aligned stores (address, 32-bit lane-replicated data, 4-bit byte enable) and queues them in FIFO order.
- Drains queued stores to memory through a req/ready handshake.
- Serves loads: loads that miss the buffer go straight to memory; loads that hit a pending store stall until that store has drained, preserving memory ordering.

---
 rtl/store_buffer.sv | 196 +++++++++++++++++++
 tb/tb_store_buffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the memory handler and the data
// memory port. Stores are queued (with coalescing into the youngest entry)
// and drained in order; loads bypass the buffer unless they hit a pending
// store, in which case they wait for that store to drain.
// Optional macro STORE_BUFFER_FWD_EN: serve a load from the youngest matching
// entry when that entry has all four byte enables set.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_we,
    input  logic              cpu_re,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_we,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int AW = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     e_addr [DEPTH];
    logic [31:0]       e_data [DEPTH];
    logic [3:0]        e_be   [DEPTH];
    logic [DEPTH-1:0]  e_valid;
    logic [PW-1:0]     head, tail, youngest;
    logic [PW:0]       count;

    logic [AW-1:0]     req_word;
    logic [ADDR_W-1:0] req_addr;
    logic              is_store, hit, fwd, coalesce, st_full, push, pop, ld_stall;
    logic [31:0]       fwd_data;

    assign req_word = cpu_addr[ADDR_W-1:2];
    assign req_addr = cpu_addr & ~ADDR_W'(3);
    assign youngest = tail - 1'b1;
    assign is_store = (cpu_we != 4'b0000);
    assign coalesce = is_store && (count >= (PW+1)'(2)) && e_valid[youngest]
                      && (e_addr[youngest] == req_word);
    assign st_full  = is_store && !coalesce && (count == (PW+1)'(DEPTH));
    assign push     = is_store && !coalesce && !st_full && !rst;
    assign sb_empty = (count == '0) && (state != WR_WAIT);

`ifdef STORE_BUFFER_FWD_EN
    logic [PW-1:0] fwd_idx;
`endif

    // Hit detection: walk entries oldest to youngest so the last match is the youngest
    always_comb begin
        logic [PW-1:0] idx;
        hit = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        fwd_idx = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (e_valid[idx] && (e_addr[idx] == req_word)) begin
                hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                fwd_idx = idx;
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign fwd      = cpu_re && hit && (e_be[fwd_idx] == 4'b1111);
    assign fwd_data = e_data[fwd_idx];
`else
    assign fwd      = 1'b0;
    assign fwd_data = '0;
`endif

    // Port FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Port arbitration, memory request outputs, load response and next state
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        cpu_rdata = '0;
        ld_stall  = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_re && !hit) begin
                    mem_req  = 1'b1;
                    mem_addr = req_addr;
                    if (mem_ready) cpu_rdata = mem_rdata;
                    else begin
                        ld_stall  = 1'b1;
                        state_nxt = RD_WAIT;
                    end
                end else begin
                    if (count != '0) begin
                        mem_req   = 1'b1;
                        mem_addr  = {e_addr[head], 2'b00};
                        mem_wdata = e_data[head];
                        mem_we    = e_be[head];
                        if (mem_ready) pop = 1'b1;
                        else           state_nxt = WR_WAIT;
                    end
                    ld_stall = cpu_re && !fwd;
                    if (fwd) cpu_rdata = fwd_data;
                end
            end
            WR_WAIT: begin
                mem_req   = 1'b1;
                mem_addr  = {e_addr[head], 2'b00};
                mem_wdata = e_data[head];
                mem_we    = e_be[head];
                if (mem_ready) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
                ld_stall = cpu_re && !fwd;
                if (fwd) cpu_rdata = fwd_data;
            end
            RD_WAIT: begin
                mem_req  = 1'b1;
                mem_addr = req_addr;
                if (mem_ready) begin
                    cpu_rdata = mem_rdata;
                    state_nxt = IDLE;
                end else begin
                    ld_stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        cpu_stall = ld_stall || st_full;
        // reset is asynchronous, so the port must go quiet in the same instant
        if (rst) begin
            mem_req   = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            mem_we    = '0;
            cpu_rdata = '0;
            cpu_stall = 1'b0;
            pop       = 1'b0;
        end
    end

    // Entry storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_addr[i] <= '0;
                e_data[i] <= '0;
                e_be[i]   <= '0;
            end
        end else begin
            if (pop) begin
                e_valid[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (push) begin
                e_valid[tail] <= 1'b1;
                e_addr[tail]  <= req_word;
                e_data[tail]  <= cpu_wdata;
                e_be[tail]    <= cpu_we;
                tail          <= tail + 1'b1;
            end
            if (coalesce) begin
                for (int unsigned b = 0; b < 4; b++)
                    if (cpu_we[b]) e_data[youngest][8*b +: 8] <= cpu_wdata[8*b +: 8];
                e_be[youngest] <= e_be[youngest] | cpu_we;
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer: reset, drain, full/wrap, coalescing,
// load hit/miss ordering and asynchronous reset during a pending write.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        sb_empty;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = '0; cpu_re = 1'b0;
        mem_rdata = '0; mem_ready = 1'b0;
        #2;
        chk("rst mem_req",  mem_req, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_we",   mem_we, 0);
        chk("rst stall",    cpu_stall, 0);
        chk("rst rdata",    cpu_rdata, 0);
        chk("rst empty",    sb_empty, 1);
        tick(); tick();
        rst = 1'b0;

        // single store with zero-wait drain
        cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF; cpu_we = 4'hF; mem_ready = 1'b1;
        #2;
        chk("t1 stall", cpu_stall, 0);
        chk("t1 req0",  mem_req, 0);
        tick(); cpu_we = '0; #2;
        chk("t1 req",   mem_req, 1);
        chk("t1 addr",  mem_addr, 32'h100);
        chk("t1 we",    mem_we, 4'hF);
        chk("t1 wdata", mem_wdata, 32'hDEADBEEF);
        chk("t1 nempty", sb_empty, 0);
        tick(); #2;
        chk("t1 empty", sb_empty, 1);
        chk("t1 idle",  mem_req, 0);

        // fill to DEPTH, fifth store stalls, pointer wrap
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 32'(4*i); cpu_wdata = 32'h1000 + 32'(i); cpu_we = 4'hF; #2;
            chk("t2 fill stall", cpu_stall, 0);
            tick();
        end
        cpu_addr = 32'h10; cpu_wdata = 32'h1004; #2;
        chk("t2 full stall", cpu_stall, 1);
        chk("t2 head addr",  mem_addr, 32'h0);
        mem_ready = 1'b1; #1;
        chk("t2 full pop stall", cpu_stall, 1);
        tick(); mem_ready = 1'b0; #2;
        chk("t2 accept",     cpu_stall, 0);
        chk("t2 next head",  mem_addr, 32'h4);
        tick(); cpu_we = '0; mem_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            #2;
            chk("t2 drain addr",  mem_addr, 32'(4*i));
            chk("t2 drain wdata", mem_wdata, 32'h1000 + 32'(i));
            tick();
        end
        #2;
        chk("t2 empty", sb_empty, 1);

        // coalescing into the youngest entry
        mem_ready = 1'b0;
        cpu_addr = 32'h20; cpu_wdata = 32'h11; cpu_we = 4'b0001; tick();
        cpu_addr = 32'h24; cpu_wdata = 32'h22; cpu_we = 4'b0001; tick();
        cpu_addr = 32'h24; cpu_wdata = 32'h3300; cpu_we = 4'b0010; #2;
        chk("t3 coal stall", cpu_stall, 0);
        tick(); cpu_we = '0; mem_ready = 1'b1; #2;
        chk("t3 head addr", mem_addr, 32'h20);
        chk("t3 head we",   mem_we, 4'b0001);
        tick(); #2;
        chk("t3 coal addr", mem_addr, 32'h24);
        chk("t3 coal we",   mem_we, 4'b0011);
        chk("t3 coal data", mem_wdata[15:0], 16'h3322);
        tick(); #2;
        chk("t3 no extra", mem_req, 0);
        chk("t3 empty",    sb_empty, 1);

        // load hitting a pending store
        mem_ready = 1'b0;
        cpu_addr = 32'h40; cpu_wdata = 32'hCAFEF00D; cpu_we = 4'hF; tick();
        cpu_we = '0; cpu_re = 1'b1; #2;
`ifdef STORE_BUFFER_FWD_EN
        chk("t4 fwd stall", cpu_stall, 0);
        chk("t4 fwd data",  cpu_rdata, 32'hCAFEF00D);
        cpu_re = 1'b0; mem_ready = 1'b1; tick(); #2;
        chk("t4 fwd empty", sb_empty, 1);
`else
        chk("t4 hit stall", cpu_stall, 1);
        chk("t4 drain we",  mem_we, 4'hF);
        chk("t4 drain addr", mem_addr, 32'h40);
        tick(); #2;
        chk("t4 wait stall", cpu_stall, 1);
        mem_ready = 1'b1; mem_rdata = 32'h12345678; #1;
        chk("t4 pop stall", cpu_stall, 1);
        tick(); #2;
        chk("t4 ld req",   mem_req, 1);
        chk("t4 ld we",    mem_we, 4'b0000);
        chk("t4 ld addr",  mem_addr, 32'h40);
        chk("t4 ld stall", cpu_stall, 0);
        chk("t4 ld data",  cpu_rdata, 32'h12345678);
        cpu_re = 1'b0;
        tick();
`endif
        mem_ready = 1'b0;

        // load miss with three wait cycles
        cpu_addr = 32'h80; cpu_re = 1'b1; mem_rdata = 32'hA5A50080;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t5 wait stall", cpu_stall, 1);
            chk("t5 ld we",      mem_we, 4'b0000);
            tick();
        end
        mem_ready = 1'b1; #2;
        chk("t5 done stall", cpu_stall, 0);
        chk("t5 data",       cpu_rdata, 32'hA5A50080);
        chk("t5 addr",       mem_addr, 32'h80);
        tick(); cpu_re = 1'b0; mem_ready = 1'b0;

        // asynchronous reset while a write is waiting
        for (int i = 0; i < 3; i++) begin
            cpu_addr = 32'h200 + 32'(4*i); cpu_wdata = 32'(i); cpu_we = 4'hF; tick();
        end
        cpu_we = '0; #2;
        chk("t6 pending req", mem_req, 1);
        chk("t6 nempty",      sb_empty, 0);
        rst = 1'b1; #1;
        chk("t6 rst req",   mem_req, 0);
        chk("t6 rst empty", sb_empty, 1);
        chk("t6 rst stall", cpu_stall, 0);
        tick(); rst = 1'b0; tick(); #2;
        chk("t6 after req",   mem_req, 0);
        chk("t6 after empty", sb_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
